// File: rtl/cpu_branch_resolver_if.sv
// Bus bundle for cpu_branch_resolver: request, result slot, flush and fetch lookup.
// master = pipeline/fetch side, slave = branch resolver.
interface cpu_branch_resolver_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_operand_a;
  logic [XLEN-1:0] in_operand_b;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_offset;
  logic            in_predicted_taken;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic            out_mispredict;
  logic            out_illegal;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;

  modport master (
    output flush, in_valid, in_funct3, in_operand_a, in_operand_b, in_pc,
           in_offset, in_predicted_taken, out_ready, pred_pc,
    input  in_ready, out_valid, out_taken, out_target, out_mispredict,
           out_illegal, out_pc, pred_taken
  );

  modport slave (
    input  flush, in_valid, in_funct3, in_operand_a, in_operand_b, in_pc,
           in_offset, in_predicted_taken, out_ready, pred_pc,
    output in_ready, out_valid, out_taken, out_target, out_mispredict,
           out_illegal, out_pc, pred_taken
  );
endinterface

// File: rtl/cpu_branch_resolver.sv
// Execute-stage branch resolver: evaluates the funct3 condition, computes the
// next PC, flags mispredictions and holds the result in a one-entry valid/ready
// slot. With CPU_BRANCH_BHT_EN defined it also owns a 2-bit saturating branch
// history table trained on retired results and read combinationally by fetch;
// without it, prediction is static not-taken.
module cpu_branch_resolver #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cpu_branch_resolver_if.slave  bus
);

  logic            accept;
  logic            out_hs;
  logic            cond_taken;
  logic            cond_illegal;
  logic [XLEN-1:0] res_target;
  logic            res_mispredict;

  logic            out_valid_q, out_valid_d;
  logic            out_taken_q;
  logic [XLEN-1:0] out_target_q;
  logic            out_mispredict_q;
  logic            out_illegal_q;
  logic [XLEN-1:0] out_pc_q;

  // Fetch lookup address is only partially decoded (or not at all without the BHT).
  logic            unused_pred_pc;
  assign unused_pred_pc = ^bus.pred_pc;

  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;
  assign out_hs       = out_valid_q & bus.out_ready;

  // Branch condition decode; 010/011 are not branches and never resolve taken.
  always_comb begin
    cond_taken   = 1'b0;
    cond_illegal = 1'b0;
    case (bus.in_funct3)
      3'b000:  cond_taken = (bus.in_operand_a == bus.in_operand_b);
      3'b001:  cond_taken = (bus.in_operand_a != bus.in_operand_b);
      3'b100:  cond_taken = ($signed(bus.in_operand_a) <  $signed(bus.in_operand_b));
      3'b101:  cond_taken = ($signed(bus.in_operand_a) >= $signed(bus.in_operand_b));
      3'b110:  cond_taken = (bus.in_operand_a <  bus.in_operand_b);
      3'b111:  cond_taken = (bus.in_operand_a >= bus.in_operand_b);
      default: cond_illegal = 1'b1;
    endcase
  end

  // Next PC wraps modulo 2^XLEN; mispredict is fixed at accept time.
  assign res_target     = cond_taken ? (bus.in_pc + bus.in_offset)
                                     : (bus.in_pc + XLEN'(4));
  assign res_mispredict = cond_taken ^ bus.in_predicted_taken;

  // Slot occupancy: flush wins, a new accept refills, a handshake drains.
  always_comb begin
    out_valid_d = out_valid_q;
    if (bus.flush)   out_valid_d = 1'b0;
    else if (accept) out_valid_d = 1'b1;
    else if (out_hs) out_valid_d = 1'b0;
  end

  // Result slot registers; data only changes on accept so a stalled result stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q      <= 1'b0;
      out_taken_q      <= 1'b0;
      out_target_q     <= '0;
      out_mispredict_q <= 1'b0;
      out_illegal_q    <= 1'b0;
      out_pc_q         <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        out_taken_q      <= cond_taken;
        out_target_q     <= res_target;
        out_mispredict_q <= res_mispredict;
        out_illegal_q    <= cond_illegal;
        out_pc_q         <= bus.in_pc;
      end
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_taken      = out_taken_q;
  assign bus.out_target     = out_target_q;
  assign bus.out_mispredict = out_mispredict_q;
  assign bus.out_illegal    = out_illegal_q;
  assign bus.out_pc         = out_pc_q;

`ifdef CPU_BRANCH_BHT_EN
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d;
  logic             bht_we;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] pred_idx;

  // Train only on retired legal branches; a flush in the same cycle suppresses it.
  assign bht_we   = out_hs & ~out_illegal_q & ~bus.flush;
  assign upd_idx  = out_pc_q[IDX_W+1:2];
  assign pred_idx = bus.pred_pc[IDX_W+1:2];

  // Saturating counter step for the retiring branch's entry.
  always_comb begin
    bht_d = bht_q[upd_idx];
    if (out_taken_q) begin
      if (bht_q[upd_idx] != 2'b11) bht_d = bht_q[upd_idx] + 2'd1;
    end else begin
      if (bht_q[upd_idx] != 2'b00) bht_d = bht_q[upd_idx] - 2'd1;
    end
  end

  // Counter storage; reset brings every entry to weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (bht_we) begin
      bht_q[upd_idx] <= bht_d;
    end
  end

  // Lookup sees the pre-update value when fetch reads the entry being trained.
  assign bus.pred_taken = bht_q[pred_idx][1];
`else
  assign bus.pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_branch_resolver.sv
// Directed bench for cpu_branch_resolver: condition decode, target wrap,
// stall/throughput handshake, illegal funct3, BHT training, flush and reset.
// Expected prediction values follow CPU_BRANCH_BHT_EN (static 0 when undefined).
module tb_cpu_branch_resolver;

`ifdef CPU_BRANCH_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total_cnt;
  int   bad_cnt;

  cpu_branch_resolver_if #(.XLEN(32)) bus ();

  cpu_branch_resolver #(.XLEN(32), .BHT_ENTRIES(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] off, input logic pred);
    bus.in_valid           = 1'b1;
    bus.in_funct3          = f3;
    bus.in_operand_a       = a;
    bus.in_operand_b       = b;
    bus.in_pc              = pc;
    bus.in_offset          = off;
    bus.in_predicted_taken = pred;
  endtask

  // Offer one request for one cycle; outputs of the accepted request are visible on return.
  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] off, input logic pred);
    drive(f3, a, b, pc, off, pred);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic taken, input logic [31:0] target,
                           input logic mis, input logic ill);
    check({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, ".taken"}, 64'(bus.out_taken), 64'(taken));
    check({tag, ".target"}, 64'(bus.out_target), 64'(target));
    check({tag, ".mispredict"}, 64'(bus.out_mispredict), 64'(mis));
    check({tag, ".illegal"}, 64'(bus.out_illegal), 64'(ill));
  endtask

  // Retire one branch at pc 0x40 (out_ready=1), then check the prediction for 0x40.
  task automatic bht_op(input string tag, input logic taken, input logic exp_pred);
    send(3'b000, 32'd7, taken ? 32'd7 : 32'd8, 32'h40, 32'h10, 1'b0);
    check({tag, ".taken"}, 64'(bus.out_taken), 64'(taken));
    tick();
    $display("bht %s taken=%0d pred_taken=%0d", tag, taken, bus.pred_taken);
    check({tag, ".pred"}, 64'(bus.pred_taken), 64'(BHT_ON & exp_pred));
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst_n     = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_funct3 = 3'b000;
    bus.in_operand_a = '0;
    bus.in_operand_b = '0;
    bus.in_pc = '0;
    bus.in_offset = '0;
    bus.in_predicted_taken = 1'b0;
    bus.out_ready = 1'b1;
    bus.pred_pc = 32'h40;

    // Reset state
    tick();
    tick();
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.out_target", 64'(bus.out_target), 64'd0);
    check("rst.out_pc", 64'(bus.out_pc), 64'd0);
    check("rst.in_ready", 64'(bus.in_ready), 64'd1);
    check("rst.pred", 64'(bus.pred_taken), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: EQ taken, predicted not-taken
    send(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    $display("txn eq pc=0x%0h taken=%0d target=0x%0h", bus.out_pc, bus.out_taken, bus.out_target);
    check_res("eq", 1'b1, 32'h120, 1'b1, 1'b0);
    check("eq.pc", 64'(bus.out_pc), 64'h100);

    // 2: signed vs unsigned compares, back-to-back with out_ready=1
    send(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b1);
    $display("txn lt taken=%0d target=0x%0h", bus.out_taken, bus.out_target);
    check_res("lt", 1'b1, 32'h210, 1'b0, 1'b0);
    send(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b1);
    $display("txn ltu taken=%0d target=0x%0h", bus.out_taken, bus.out_target);
    check_res("ltu", 1'b0, 32'h204, 1'b1, 1'b0);
    send(3'b111, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b0);
    $display("txn geu taken=%0d target=0x%0h", bus.out_taken, bus.out_target);
    check_res("geu", 1'b1, 32'h210, 1'b1, 1'b0);
    send(3'b001, 32'd1, 32'd1, 32'hFFFF_FFFC, 32'h100, 1'b0);
    $display("txn wrap taken=%0d target=0x%0h", bus.out_taken, bus.out_target);
    check_res("wrap", 1'b0, 32'h0, 1'b0, 1'b0);
    send(3'b101, 32'h8000_0000, 32'd0, 32'h800, 32'h40, 1'b1);
    $display("txn ge_neg taken=%0d target=0x%0h", bus.out_taken, bus.out_target);
    check_res("ge_neg", 1'b0, 32'h804, 1'b1, 1'b0);
    send(3'b101, 32'd5, 32'd5, 32'h800, 32'h40, 1'b1);
    $display("txn ge_eq taken=%0d", bus.out_taken);
    check_res("ge_eq", 1'b1, 32'h840, 1'b0, 1'b0);
    send(3'b100, 32'd5, 32'd5, 32'h800, 32'h40, 1'b0);
    $display("txn lt_eq taken=%0d", bus.out_taken);
    check_res("lt_eq", 1'b0, 32'h804, 1'b0, 1'b0);
    tick();
    check("drain.out_valid", 64'(bus.out_valid), 64'd0);

    // 3: stall for 3 cycles, then full-throughput resume
    bus.out_ready = 1'b0;
    send(3'b000, 32'd1, 32'd2, 32'h300, 32'h8, 1'b0);
    check_res("stall.first", 1'b0, 32'h304, 1'b0, 1'b0);
    drive(3'b001, 32'd1, 32'd2, 32'h400, 32'h8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("stall.in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      $display("txn stall cycle=%0d out_pc=0x%0h", i, bus.out_pc);
      check("stall.valid", 64'(bus.out_valid), 64'd1);
      check("stall.pc", 64'(bus.out_pc), 64'h300);
      check("stall.target", 64'(bus.out_target), 64'h304);
    end
    bus.out_ready = 1'b1;
    #1;
    check("resume.in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    $display("txn resume out_pc=0x%0h target=0x%0h", bus.out_pc, bus.out_target);
    check_res("resume.a", 1'b1, 32'h408, 1'b0, 1'b0);
    check("resume.a.pc", 64'(bus.out_pc), 64'h400);
    drive(3'b110, 32'd3, 32'd2, 32'h500, 32'h8, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    $display("txn resume out_pc=0x%0h target=0x%0h", bus.out_pc, bus.out_target);
    check_res("resume.b", 1'b0, 32'h504, 1'b0, 1'b0);
    check("resume.b.pc", 64'(bus.out_pc), 64'h500);
    tick();
    check("resume.drain", 64'(bus.out_valid), 64'd0);

    // 5 + 4: BHT training at 0x40, illegal retirement in between must not train
    check("bht.init", 64'(bus.pred_taken), 64'd0);
    bht_op("t1", 1'b1, 1'b1);
    bht_op("t2", 1'b1, 1'b1);
    send(3'b010, 32'd3, 32'd3, 32'h40, 32'h10, 1'b1);
    $display("txn illegal taken=%0d illegal=%0d mis=%0d", bus.out_taken, bus.out_illegal, bus.out_mispredict);
    check_res("illegal", 1'b0, 32'h44, 1'b1, 1'b1);
    tick();
    check("illegal.pred", 64'(bus.pred_taken), 64'(BHT_ON));
    bht_op("n1", 1'b0, 1'b1);
    bht_op("n2", 1'b0, 1'b0);
    bht_op("n3", 1'b0, 1'b0);
    bht_op("n4", 1'b0, 1'b0);
    bht_op("t3", 1'b1, 1'b0);
    bht_op("t4", 1'b1, 1'b1);

    // 6: flush kills held result and incoming request, no training
    bus.out_ready = 1'b0;
    send(3'b000, 32'd1, 32'd2, 32'h40, 32'h10, 1'b0);
    check("flush.pre_valid", 64'(bus.out_valid), 64'd1);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(3'b000, 32'd1, 32'd1, 32'h700, 32'h10, 1'b0);
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    $display("txn flush out_valid=%0d pred=%0d", bus.out_valid, bus.pred_taken);
    check("flush.valid", 64'(bus.out_valid), 64'd0);
    check("flush.pred", 64'(bus.pred_taken), 64'(BHT_ON));
    tick();
    check("flush.lost", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset in the middle of a held result
    bus.out_ready = 1'b0;
    send(3'b000, 32'd9, 32'd9, 32'h40, 32'h10, 1'b0);
    check("arst.pre_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("txn async_reset out_valid=%0d pred=%0d", bus.out_valid, bus.pred_taken);
    check("arst.valid", 64'(bus.out_valid), 64'd0);
    check("arst.pc", 64'(bus.out_pc), 64'd0);
    check("arst.pred", 64'(bus.pred_taken), 64'd0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    send(3'b001, 32'd4, 32'd6, 32'h900, 32'hFFFF_FFF0, 1'b1);
    $display("txn post_reset taken=%0d target=0x%0h", bus.out_taken, bus.out_target);
    check_res("post_rst", 1'b1, 32'h8F0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
